// File: rtl/ram_pkg.sv
// Shared types and default sizing for the dual-port RAM with power-up clear.
package ram_pkg;

    localparam int RAM_DATA_W_DEF = 8;
    localparam int RAM_ADDR_W_DEF = 12;
    localparam int RAM_DEPTH_DEF  = 1 << RAM_ADDR_W_DEF;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_dp_core.sv
// True dual-port, read-first synchronous storage array; no reset on contents or read registers.
module ram_dp_core #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              a_we,
    input  logic              a_re,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WORD_W-1:0] a_din,
    output logic [WORD_W-1:0] a_dout,
    input  logic              b_we,
    input  logic              b_re,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WORD_W-1:0] b_din,
    output logic [WORD_W-1:0] b_dout
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] a_dout_q;
    logic [WORD_W-1:0] b_dout_q;

    // Reads sample the array before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (b_we) mem_q[b_addr] <= b_din;
        if (a_we) mem_q[a_addr] <= a_din;
        if (a_re) a_dout_q <= mem_q[a_addr];
        if (b_re) b_dout_q <= mem_q[b_addr];
    end

    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;

endmodule

// File: rtl/ram_memory_dp.sv
// Dual-port RAM wrapper: power-up clear sequence, collision handling, read valid and
// optional even-parity protection enabled by macro RAM_MEMORY_DP_PARITY_EN.
module ram_memory_dp
    import ram_pkg::*;
#(
    parameter int                DATA_W    = RAM_DATA_W_DEF,
    parameter int                ADDR_W    = RAM_ADDR_W_DEF,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data_in,
    input  logic [DATA_W-1:0] b_data_in,
    input  logic              a_we,
    input  logic              b_we,
    input  logic              a_re,
    input  logic              b_re,
    output logic [DATA_W-1:0] a_data_out,
    output logic [DATA_W-1:0] b_data_out,
    output logic              a_valid,
    output logic              b_valid,
    output logic              ready,
    output logic              collision
`ifdef RAM_MEMORY_DP_PARITY_EN
    ,
    output logic              a_parity_err,
    output logic              b_parity_err
`endif
);

`ifdef RAM_MEMORY_DP_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef RAM_MEMORY_DP_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic              a_valid_q, a_valid_d;
    logic              b_valid_q, b_valid_d;
    logic              collision_q, collision_d;
    logic              a_seen_q, a_seen_d;
    logic              b_seen_q, b_seen_d;

    logic              run;
    logic              a_rd, b_rd;
    logic              same_addr_wr;
    logic              core_a_we, core_b_we;
    logic [ADDR_W-1:0] core_a_addr;
    logic [WORD_W-1:0] core_a_din, core_b_din;
    logic [WORD_W-1:0] core_a_dout, core_b_dout;

    assign run          = (state_q == RUN);
    assign a_rd         = run && a_re && !a_we;
    assign b_rd         = run && b_re && !b_we;
    assign same_addr_wr = run && a_we && b_we && (a_addr == b_addr);

    // During CLEAR port A of the array is owned by the clear counter; user ports are ignored.
    always_comb begin
        core_a_we   = 1'b0;
        core_a_addr = a_addr;
        core_a_din  = pack_word(a_data_in);
        core_b_we   = 1'b0;
        core_b_din  = pack_word(b_data_in);
        if (!run) begin
            core_a_we   = 1'b1;
            core_a_addr = clr_cnt_q;
            core_a_din  = pack_word(CLEAR_VAL);
        end else begin
            core_a_we = a_we;
            core_b_we = b_we && !same_addr_wr;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ready_d     = ready_q;
        a_valid_d   = a_rd;
        b_valid_d   = b_rd;
        collision_d = same_addr_wr;
        a_seen_d    = a_seen_q || a_rd;
        b_seen_d    = b_seen_q || b_rd;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            ready_q     <= 1'b0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            collision_q <= 1'b0;
            a_seen_q    <= 1'b0;
            b_seen_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ready_q     <= ready_d;
            a_valid_q   <= a_valid_d;
            b_valid_q   <= b_valid_d;
            collision_q <= collision_d;
            a_seen_q    <= a_seen_d;
            b_seen_q    <= b_seen_d;
        end
    end

    ram_dp_core #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk    (clk),
        .a_we   (core_a_we),
        .a_re   (a_rd),
        .a_addr (core_a_addr),
        .a_din  (core_a_din),
        .a_dout (core_a_dout),
        .b_we   (core_b_we),
        .b_re   (b_rd),
        .b_addr (b_addr),
        .b_din  (core_b_din),
        .b_dout (core_b_dout)
    );

    // The array's read registers have no reset, so output zero until a port has read once.
    assign a_data_out = a_seen_q ? core_a_dout[DATA_W-1:0] : '0;
    assign b_data_out = b_seen_q ? core_b_dout[DATA_W-1:0] : '0;
    assign a_valid    = a_valid_q;
    assign b_valid    = b_valid_q;
    assign ready      = ready_q;
    assign collision  = collision_q;

`ifdef RAM_MEMORY_DP_PARITY_EN
    assign a_parity_err = a_valid_q && (^core_a_dout);
    assign b_parity_err = b_valid_q && (^core_b_dout);
`endif

endmodule

// File: tb/tb_ram_memory_dp.sv
// Self-checking bench for ram_memory_dp (ADDR_W=4) against an array-based reference model.
module tb_ram_memory_dp;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data_in, b_data_in;
    logic          a_we, b_we, a_re, b_re;
    logic [DW-1:0] a_data_out, b_data_out;
    logic          a_valid, b_valid, ready, collision;
`ifdef RAM_MEMORY_DP_PARITY_EN
    logic          a_parity_err, b_parity_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_a_out, exp_b_out;

    ram_memory_dp #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .CLEAR_VAL (8'h00)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .a_addr       (a_addr),
        .b_addr       (b_addr),
        .a_data_in    (a_data_in),
        .b_data_in    (b_data_in),
        .a_we         (a_we),
        .b_we         (b_we),
        .a_re         (a_re),
        .b_re         (b_re),
        .a_data_out   (a_data_out),
        .b_data_out   (b_data_out),
        .a_valid      (a_valid),
        .b_valid      (b_valid),
        .ready        (ready),
        .collision    (collision)
`ifdef RAM_MEMORY_DP_PARITY_EN
        ,
        .a_parity_err (a_parity_err),
        .b_parity_err (b_parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = 1'b0; a_re = 1'b0; b_we = 1'b0; b_re = 1'b0;
        a_addr = '0; b_addr = '0; a_data_in = '0; b_data_in = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        exp_a_out = 8'h00;
        exp_b_out = 8'h00;
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk(tag, cyc, 16);
    endtask

    // One access cycle on both ports, predicted from the memory rules, then checked.
    task automatic do_op(input string tag,
                         input logic awe, input logic are, input logic [AW-1:0] aad, input logic [DW-1:0] adi,
                         input logic bwe, input logic bre, input logic [AW-1:0] bad, input logic [DW-1:0] bdi);
        logic ev_a, ev_b, ecol;
        a_we = awe; a_re = are; a_addr = aad; a_data_in = adi;
        b_we = bwe; b_re = bre; b_addr = bad; b_data_in = bdi;
        ev_a = are && !awe;
        ev_b = bre && !bwe;
        ecol = awe && bwe && (aad == bad);
        if (ev_a) exp_a_out = model[aad];
        if (ev_b) exp_b_out = model[bad];
        if (bwe && !ecol) model[bad] = bdi;
        if (awe) model[aad] = adi;
        tick();
        idle();
        chk({tag, ".a_valid"}, a_valid, ev_a);
        chk({tag, ".a_data"}, a_data_out, exp_a_out);
        chk({tag, ".b_valid"}, b_valid, ev_b);
        chk({tag, ".b_data"}, b_data_out, exp_b_out);
        chk({tag, ".collision"}, collision, ecol);
`ifdef RAM_MEMORY_DP_PARITY_EN
        chk({tag, ".a_perr"}, a_parity_err, 1'b0);
        chk({tag, ".b_perr"}, b_parity_err, 1'b0);
`endif
    endtask

    initial begin
        logic          awe, are, bwe, bre;
        logic [AW-1:0] aad, bad;
        logic [DW-1:0] adi, bdi;

        idle();
        model_clear();
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst.ready", ready, 1'b0);
        chk("rst.a_valid", a_valid, 1'b0);
        chk("rst.b_valid", b_valid, 1'b0);
        chk("rst.collision", collision, 1'b0);
        chk("rst.a_data", a_data_out, 8'h00);
        chk("rst.b_data", b_data_out, 8'h00);

        reset_n = 1'b1;
        wait_ready("clear1.cycles");

        for (int i = 0; i < DEPTH; i++)
            do_op("clear1.read", 1'b0, 1'b1, AW'(i), 8'h00, 1'b0, 1'b1, AW'(DEPTH - 1 - i), 8'h00);

        do_op("wr3", 1'b1, 1'b0, 4'h3, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00);
        do_op("rd3", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 8'h00);
        chk("rd3.const", b_data_out, 8'h5A);

        do_op("col7", 1'b1, 1'b0, 4'h7, 8'h11, 1'b1, 1'b0, 4'h7, 8'h22);
        chk("col7.pulse", collision, 1'b1);
        do_op("col7.after", 1'b0, 1'b1, 4'h7, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        chk("col7.drop", collision, 1'b0);
        chk("col7.value", a_data_out, 8'h11);

        do_op("rf7", 1'b1, 1'b0, 4'h7, 8'h33, 1'b0, 1'b1, 4'h7, 8'h00);
        chk("rf7.old", b_data_out, 8'h11);
        do_op("rf7.new", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h7, 8'h00);
        chk("rf7.new.const", b_data_out, 8'h33);

        do_op("we_prio", 1'b1, 1'b1, 4'h9, 8'hC3, 1'b0, 1'b0, 4'h0, 8'h00);
        chk("we_prio.hold", a_data_out, 8'h11);

        do_op("wr_diff", 1'b1, 1'b0, 4'h1, 8'hA1, 1'b1, 1'b0, 4'hE, 8'hB2);
        do_op("rd_diff", 1'b0, 1'b1, 4'hE, 8'h00, 1'b0, 1'b1, 4'h1, 8'h00);
        chk("rd_diff.a", a_data_out, 8'hB2);
        chk("rd_diff.b", b_data_out, 8'hA1);

        for (int i = 0; i < 300; i++) begin
            awe = 1'($urandom_range(0, 1));
            are = 1'($urandom_range(0, 1));
            bwe = 1'($urandom_range(0, 1));
            bre = 1'($urandom_range(0, 1));
            aad = AW'($urandom);
            bad = ($urandom_range(0, 3) == 0) ? aad : AW'($urandom);
            adi = DW'($urandom);
            bdi = DW'($urandom);
            do_op("rand", awe, are, aad, adi, bwe, bre, bad, bdi);
        end

        reset_n = 1'b0;
        #1;
        chk("rst2.ready", ready, 1'b0);
        chk("rst2.a_valid", a_valid, 1'b0);
        chk("rst2.a_data", a_data_out, 8'h00);
        chk("rst2.b_data", b_data_out, 8'h00);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_we = 1'b1; a_addr = 4'hF; a_data_in = 8'hFF;
            tick();
            chk("clear2.ready_low", ready, 1'b0);
        end
        idle();
        reset_n = 1'b0;
        #1;
        chk("rst3.ready", ready, 1'b0);
        tick();
        reset_n = 1'b1;
        model_clear();
        wait_ready("clear3.cycles");
        for (int i = 0; i < DEPTH; i++)
            do_op("clear3.read", 1'b0, 1'b1, AW'(i), 8'h00, 1'b0, 1'b1, AW'(i), 8'h00);

`ifdef RAM_MEMORY_DP_PARITY_EN
        do_op("par.wr", 1'b1, 1'b0, 4'h2, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00);
        do_op("par.rd", 1'b0, 1'b1, 4'h2, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        u_dut.u_core.mem_q[2] = u_dut.u_core.mem_q[2] ^ 9'h001;
        a_re = 1'b1; a_addr = 4'h2;
        tick();
        idle();
        chk("par.flip.valid", a_valid, 1'b1);
        chk("par.flip.err", a_parity_err, 1'b1);
        chk("par.flip.data", a_data_out, 8'h5B);
        tick();
        chk("par.flip.clear", a_parity_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_memory_dp.md
RAM_MEMORY_DP -- requirements
Module: ram_memory_dp

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_W, default 12, SHALL set the address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter CLEAR_VAL, default 0, SHALL set the word value written to every location by the clear sequence.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Ports a_addr, b_addr, input, ADDR_W bits: word address for port A and port B.
REQ-007 Ports a_data_in, b_data_in, input, DATA_W bits: write data.
REQ-008 Ports a_we, b_we, input, 1 bit: write enable.
REQ-009 Ports a_re, b_re, input, 1 bit: read enable.
REQ-010 Ports a_data_out, b_data_out, output, DATA_W bits: registered read data.
REQ-011 Ports a_valid, b_valid, output, 1 bit: read data valid, one-cycle pulse.
REQ-012 Port ready, output, 1 bit: high when the clear sequence is done and accesses are accepted.
REQ-013 Port collision, output, 1 bit: one-cycle pulse when a port B write is dropped.

Function
REQ-014 The block SHALL have two states: CLEAR and RUN.
REQ-015 In CLEAR, an ADDR_W-bit counter SHALL write CLEAR_VAL to one location per cycle, address 0 upward; port inputs SHALL be ignored and ready SHALL be low.
REQ-016 CLEAR SHALL last exactly 2**ADDR_W cycles, then go to RUN; ready SHALL rise in the cycle after the last word (2**ADDR_W-1) is written.
REQ-017 In RUN, ready SHALL stay high until the next reset.
REQ-018 A read (re=1, we=0) SHALL show the addressed word on data_out with valid=1 one cycle later (latency 1).
REQ-019 data_out SHALL hold its last value when valid=0.
REQ-020 On one port, we=1 SHALL take priority over re: the cycle SHALL be a write only, with no valid pulse and data_out unchanged.
REQ-021 A write SHALL update the addressed word at the rising edge of the cycle in which we=1.
REQ-022 If one port reads the address the other port writes in the same cycle, the read SHALL return the old (pre-write) data.
REQ-023 If both ports write the same address in the same cycle, port A SHALL win, the port B write SHALL be dropped, and collision SHALL pulse for one cycle.
REQ-024 Writes by both ports to different addresses in the same cycle SHALL both complete.
REQ-025 Addresses SHALL wrap modulo 2**ADDR_W; no out-of-range condition exists.

Reset
REQ-026 While reset_n=0: state=CLEAR, clear counter=0, data_out=0, valid=0, ready=0, collision=0.
REQ-027 When reset_n is asserted mid-CLEAR or mid-RUN, the clear SHALL restart from address 0 after release; an access in flight SHALL be dropped.
REQ-028 Memory contents SHALL NOT be reset asynchronously; only the clear sequence initialises them.

Configuration
REQ-029 With macro RAM_MEMORY_DP_PARITY_EN defined, each word SHALL store one extra even-parity bit computed on write (the clear writes parity of CLEAR_VAL).
REQ-030 With the macro defined, outputs a_parity_err and b_parity_err (1 bit, reset 0) SHALL pulse together with valid when the stored parity does not match the read data.
REQ-031 Without the macro, no parity storage SHALL exist and the parity_err ports SHALL be absent.

Structure
REQ-032 A shared package ram_pkg SHALL hold the state typedef (CLEAR, RUN) and the default width and depth constants.
REQ-033 The storage array SHALL be one sub-module, ram_dp_core: a true dual-port, read-first synchronous array with no reset; clear control, collision logic, valid and parity SHALL live in ram_memory_dp.

Verification
REQ-034 Reset, ADDR_W=4: ready rises exactly 16 cycles after reset_n rises; reading any address then returns 0x00.
REQ-035 Port A writes 0x5A to 0x003; next cycle port B reads 0x003 -> b_data_out=0x5A with b_valid=1 one cycle later.
REQ-036 Same cycle: A writes 0x11 to 0x007 and B writes 0x22 to 0x007 -> collision=1 for one cycle; a later read of 0x007 returns 0x11.
REQ-037 0x007 holds 0x11; A writes 0x33 to it while B reads it -> B returns 0x11; the next read returns 0x33.
REQ-038 reset_n pulsed low at clear address 0x8 -> ready stays low and the clear restarts at 0; ready rises 16 cycles after release.
REQ-039 With RAM_MEMORY_DP_PARITY_EN, force-flip one stored data bit at 0x002 -> the read of 0x002 gives a_parity_err=1 coincident with a_valid.
